// File: rtl/mult_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mult_pkg
// Purpose  : Shared definitions for the iterative shift-add multiplier:
//            operand width and the sequencer state encoding.
// Revision : 1.0 - initial release
// ============================================================================
package mult_pkg;

    localparam int MULT_W = 16;

    // 2-bit encoding; 2'b11 is unused and recovers to IDLE.
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

endpackage : mult_pkg
`default_nettype wire

// File: rtl/zero_detect16.sv
`default_nettype none
// ============================================================================
// Module   : zero_detect16
// Purpose  : 16-bit all-zeros detector.
// Ports    : in   [15:0] - value to test
//            zero        - high when every bit of in is 0
// Revision : 1.0 - initial release
// ============================================================================
module zero_detect16 (
    input  logic [15:0] in,
    output logic        zero
);

    assign zero = ~(|in);

endmodule : zero_detect16
`default_nettype wire

// File: rtl/mult_seq.sv
`default_nettype none
// ============================================================================
// Module   : mult_seq
// Purpose  : Iterative unsigned shift-add multiplier (one add/shift step per
//            cycle) with early termination once the remaining multiplier bits
//            are all zero. Pulses done and holds product, zero and ovf until
//            the next accepted start.
// Ports    : clk            - clock, rising edge
//            rst_n          - asynchronous active-low reset
//            start          - request, sampled only while idle
//            a, b           - multiplicand / multiplier, captured on accept
//            busy           - high from the cycle after accept through done
//            done           - one-cycle completion pulse
//            product        - 2*WIDTH result, held until the next accept
//            zero           - product == 0
//            ovf            - upper half of product is non-zero
// Revision : 1.0 - initial release
// ============================================================================
module mult_seq
    import mult_pkg::*;
#(
    parameter int WIDTH = MULT_W
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product,
    output logic                 zero,
    output logic                 ovf
);

    state_t               r_state;
    state_t               w_state_nxt;
    logic [2*WIDTH-1:0]   r_acc;
    logic [2*WIDTH-1:0]   r_mcand;
    logic [WIDTH-1:0]     r_mplier;

    logic                 w_mplier_zero;
    logic                 w_acc_hi_zero;
    logic                 w_acc_lo_zero;

    // Early-termination test: no multiplier bits left means no more adds.
    zero_detect16 u_zd_mplier (
        .in   (r_mplier),
        .zero (w_mplier_zero)
    );

    // Flag detectors look at the accumulator so that the flags can be loaded
    // in the same edge as the product.
    zero_detect16 u_zd_acc_hi (
        .in   (r_acc[2*WIDTH-1:WIDTH]),
        .zero (w_acc_hi_zero)
    );

    zero_detect16 u_zd_acc_lo (
        .in   (r_acc[WIDTH-1:0]),
        .zero (w_acc_lo_zero)
    );

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_acc    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            product  <= '0;
            zero     <= 1'b1;
            ovf      <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_mcand  <= {{WIDTH{1'b0}}, a};
                        r_mplier <= b;
                        r_acc    <= '0;
                    end
                end
                RUN: begin
                    if (w_mplier_zero) begin
                        // Last RUN cycle: publish the result for the DONE cycle.
                        product <= r_acc;
                        zero    <= w_acc_hi_zero & w_acc_lo_zero;
                        ovf     <= ~w_acc_hi_zero;
                    end else begin
                        // Sum of partial products never exceeds 2*WIDTH bits,
                        // so the adder carry-out is safely dropped.
                        if (r_mplier[0]) begin
                            r_acc <= r_acc + r_mcand;
                        end
                        r_mcand  <= r_mcand << 1;
                        r_mplier <= r_mplier >> 1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Next-state decode.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (start) w_state_nxt = RUN;
            RUN:     if (w_mplier_zero) w_state_nxt = DONE;
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Status outputs depend on the state register only.
    assign busy = (r_state == RUN) || (r_state == DONE);
    assign done = (r_state == DONE);

endmodule : mult_seq
`default_nettype wire

// File: tb/tb_mult_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_mult_seq
// Purpose  : Self-checking bench for mult_seq: directed corner cases plus
//            randomized operand pairs against a behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mult_seq;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [15:0] a;
    logic [15:0] b;
    logic        busy;
    logic        done;
    logic [31:0] product;
    logic        zero;
    logic        ovf;

    int          n_tests;
    int          n_fail;
    logic [31:0] prev_prod;   // last published product, must hold between ops

    mult_seq #(.WIDTH(16)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .a       (a),
        .b       (b),
        .busy    (busy),
        .done    (done),
        .product (product),
        .zero    (zero),
        .ovf     (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference latency: cycle index of done, counted from the accept cycle.
    function automatic int exp_done_cycle(input logic [15:0] mb);
        int k;
        k = -1;
        for (int i = 0; i < 16; i++) if (mb[i]) k = i;
        return (k < 0) ? 2 : k + 3;
    endfunction

    // One operation. Called straight after a previous one it starts in the
    // idle cycle following done, i.e. back-to-back.
    // If inject is set, a different start request is pulsed during RUN.
    task automatic run_op(input logic [15:0] oa, input logic [15:0] ob, input bit inject);
        int          cyc;
        int          expc;
        logic [31:0] expp;
        expp = {16'h0, oa} * {16'h0, ob};
        expc = exp_done_cycle(ob);

        @(negedge clk);                      // cycle 0 (idle)
        check("idle_done", {31'b0, done}, 32'd0);
        check("idle_busy", {31'b0, busy}, 32'd0);
        start = 1'b1; a = oa; b = ob;
        @(negedge clk);                      // cycle 1
        start = 1'b0; a = ~oa; b = ~ob;      // operands may change after accept
        cyc = 1;
        check("busy_c1", {31'b0, busy}, 32'd1);
        check("hold_prod", product, prev_prod);
        while (!done && cyc < 30) begin
            if (inject && cyc == 2) begin
                start = 1'b1; a = 16'h0003; b = 16'h0003;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        check("done_cyc", cyc, expc);
        check("product", product, expp);
        check("zero", {31'b0, zero}, {31'b0, (expp == 32'd0)});
        check("ovf", {31'b0, ovf}, {31'b0, (expp[31:16] != 16'd0)});
        check("busy_done", {31'b0, busy}, 32'd1);
        prev_prod = expp;
    endtask

    initial begin
        int   saw_done;
        logic [15:0] ra, rb;
        n_tests = 0; n_fail = 0; prev_prod = 32'd0;
        rst_n = 1'b0; start = 1'b0; a = '0; b = '0;
        repeat (3) @(negedge clk);
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_done", {31'b0, done}, 32'd0);
        check("rst_prod", product, 32'd0);
        check("rst_zero", {31'b0, zero}, 32'd1);
        check("rst_ovf", {31'b0, ovf}, 32'd0);
        rst_n = 1'b1;

        // Directed cases.
        run_op(16'd7, 16'd5, 1'b0);
        run_op(16'hFFFF, 16'h0000, 1'b0);
        run_op(16'hFFFF, 16'hFFFF, 1'b0);
        run_op(16'h1234, 16'h00F1, 1'b1);    // request during RUN ignored
        run_op(16'h0000, 16'h8000, 1'b0);    // worst latency, zero product
        run_op(16'h8000, 16'h8000, 1'b0);

        // Reset in the middle of RUN.
        @(negedge clk);
        start = 1'b1; a = 16'h1234; b = 16'hFFFF;
        @(negedge clk);                      // cycle 1
        start = 1'b0;
        repeat (4) @(negedge clk);           // cycle 5
        rst_n = 1'b0;
        #1;
        check("mrst_busy", {31'b0, busy}, 32'd0);
        check("mrst_done", {31'b0, done}, 32'd0);
        check("mrst_prod", product, 32'd0);
        check("mrst_zero", {31'b0, zero}, 32'd1);
        check("mrst_ovf", {31'b0, ovf}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        saw_done = 0;
        repeat (25) begin
            @(negedge clk);
            if (done) saw_done++;
        end
        check("mrst_nodone", saw_done, 0);
        prev_prod = 32'd0;

        // Random pairs; some multipliers masked down to exercise short runs.
        for (int i = 0; i < 3000; i++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            if ((i % 4) == 1) rb = rb >> $urandom_range(15, 0);
            run_op(ra, rb, (i % 7) == 0);
        end

        @(negedge clk);
        check("final_done", {31'b0, done}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_mult_seq
`default_nettype wire
